// File: rtl/sha256_chain.sv
// sha256_chain: SHA-256 compression engine with multi-block chaining.
//   Accepts one padded 512-bit block per valid/ready handshake and keeps the
//   chaining value between blocks internally. The digest is emitted only after
//   the block flagged last, and is held until the consumer takes it.
// Parameters:
//   RPC    rounds per clock (1, 2 or 4); the round datapath is unrolled RPC times
//   EXT_IV 0: first block chains from standard H0; 1: first block chains from iv_in
// Ports:
//   clk, n_rst            clock (rising edge), async active-low reset
//   in_valid/in_ready     block handshake; in_ready high only in IDLE
//   in_block              W0 in [511:480]
//   in_first, in_last     message start / end flags, sampled on accept
//   iv_in                 external IV {A..H}, A in [255:224]
//   out_valid/out_ready   digest handshake
//   digest                H0..H7, H0 in [255:224]
module sha256_chain #(
  parameter int RPC    = 1,
  parameter bit EXT_IV = 1'b0
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [255:0] iv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [5:0] STEP     = 6'(RPC);
  localparam logic [5:0] LAST_CNT = 6'(64 - RPC);

  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One compression round on packed {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] round_f(input logic [255:0] v,
                                           input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = v;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Window slot i holds W[t+i]; slide by one and append W[t+16].
  // Words produced during the last 16 rounds are never consumed.
  function automatic logic [15:0][31:0] shift_f(input logic [15:0][31:0] w);
    logic [15:0][31:0] n;
    n[14:0] = w[15:1];
    n[15]   = (ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3)) + w[0];
    return n;
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  logic [1:0]        state;
  logic [5:0]        cnt;
  logic              last;
  logic [255:0]      chain, vars;
  logic [15:0][31:0] win, blk_win;
  logic [255:0]      chain_sel, chain_sum;
  logic [255:0]      vs [0:RPC];
  logic [15:0][31:0] ws [0:RPC];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign chain_sel = in_first ? (EXT_IV ? iv_in : H_INIT) : chain;
  assign chain_sum = add8(chain, vars);

  always_comb begin
    for (int i = 0; i < 16; i++) blk_win[i] = in_block[511 - 32*i -: 32];
  end

  // RPC rounds chained combinationally; each consumes the window head.
  always_comb begin
    vs[0] = vars;
    ws[0] = win;
    for (int r = 0; r < RPC; r++) begin
      vs[r+1] = round_f(vs[r], K[cnt + 6'(r)], ws[r][0]);
      ws[r+1] = shift_f(ws[r]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 1'b0;
      chain  <= H_INIT;
      vars   <= '0;
      win    <= '0;
      digest <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          win   <= blk_win;
          chain <= chain_sel;
          vars  <= chain_sel;
          last  <= in_last;
          cnt   <= '0;
          state <= ROUND;
        end
        ROUND: begin
          vars <= vs[RPC];
          win  <= ws[RPC];
          cnt  <= cnt + STEP;
          if (cnt == LAST_CNT) state <= FINAL;
        end
        FINAL: begin
          chain <= chain_sum;
          if (last) begin
            digest <= chain_sum;
            state  <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_chain.sv
// tb_sha256_chain: scoreboard bench for sha256_chain.
//   Four instances: RPC=1, RPC=2, RPC=4 (EXT_IV=0) and RPC=4 with EXT_IV=1.
//   The driver pushes expected digest + latency per accepted last block; a
//   monitor pops and compares on every rising out_valid.
module tb_sha256_chain;
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1    = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2    = {480'h0, 32'h000001c0};

  localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] H_INIT  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] H1      = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [511:0] in_block;
  logic         in_first, in_last;
  logic [255:0] iv_in;
  logic         in_valid_a [4];
  logic         in_ready_a [4];
  logic         out_valid_a [4];
  logic         out_ready_a [4];
  logic [255:0] digest_a [4];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [255:0] dig;
    int           lat;
    int           acc;
  } exp_t;
  exp_t       q [4][$];
  exp_t       mon_e;
  logic [3:0] ov_prev = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_chain #(.RPC(g == 0 ? 1 : (g == 1 ? 2 : 4)), .EXT_IV(g == 3)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_block  (in_block),
      .in_first  (in_first),
      .in_last   (in_last),
      .iv_in     (iv_in),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .digest    (digest_a[g])
    );
  end

  function automatic int rpc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every rising out_valid must match the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (n_rst && out_valid_a[d] && !ov_prev[d]) begin
        tests++;
        if (q[d].size() == 0) begin
          fails++;
          $display("FAIL unexpected_out dut%0d: got digest %h want no output", d, digest_a[d]);
        end else begin
          mon_e = q[d].pop_front();
          if (digest_a[d] !== mon_e.dig) begin
            fails++;
            $display("FAIL digest dut%0d: got %h want %h", d, digest_a[d], mon_e.dig);
          end
          tests++;
          if (cyc - mon_e.acc != mon_e.lat) begin
            fails++;
            $display("FAIL latency dut%0d: got %0d want %0d", d, cyc - mon_e.acc, mon_e.lat);
          end
        end
      end
      ov_prev[d] = out_valid_a[d];
    end
  end

  // Offer one block to instance d; returns one cycle after the accept edge
  // (or after `hold` extra cycles with in_valid still asserted).
  task automatic send(input int d, input logic [511:0] blk, input bit first, input bit last,
                      input logic [255:0] iv, input bit push, input logic [255:0] dig,
                      input int hold);
    int n = 0;
    int bad = 0;
    @(negedge clk);
    in_block = blk;
    in_first = first;
    in_last  = last;
    iv_in    = iv;
    in_valid_a[d] = 1'b1;
    while (!in_ready_a[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout dut%0d: got in_ready=0 want 1", d);
      in_valid_a[d] = 1'b0;
      return;
    end
    if (push) q[d].push_back('{dig, 64 / rpc_of(d) + 2, cyc});
    @(negedge clk);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (in_ready_a[d] !== 1'b0) bad++;
        @(negedge clk);
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL busy_ignore dut%0d: got in_ready high %0d times want 0", d, bad);
      end
    end
    in_valid_a[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while ((q[d].size() != 0 || !in_ready_a[d]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL done_timeout dut%0d: got pending=%0d want 0", d, q[d].size());
    end
  endtask

  initial begin
    int n;
    int bad;
    in_block = '0;
    in_first = 1'b0;
    in_last  = 1'b0;
    iv_in    = '0;
    for (int d = 0; d < 4; d++) begin
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_in_ready", 256'(in_ready_a[d]), 256'd1);
      chk("rst_out_valid", 256'(out_valid_a[d]), 256'd0);
      chk("rst_digest", digest_a[d], 256'd0);
    end
    n_rst = 1'b1;

    // Empty message, then "abc" at every unroll factor.
    send(0, EMPTY, 1, 1, '0, 1, EMPTY_D, 0);
    wait_done(0);
    for (int d = 0; d < 3; d++) begin
      send(d, ABC, 1, 1, '0, 1, ABC_D, 0);
      wait_done(d);
    end

    // Two-block message: no output after block 1, digest keeps old value.
    send(0, B1, 1, 0, '0, 0, '0, 0);
    wait_done(0);
    chk("mid_out_valid", 256'(out_valid_a[0]), 256'd0);
    chk("digest_kept", digest_a[0], ABC_D);
    send(0, B2, 0, 1, '0, 1, TWO_D, 0);
    wait_done(0);

    // Backpressure on the RPC=4 instance.
    out_ready_a[2] = 1'b0;
    send(2, ABC, 1, 1, '0, 1, ABC_D, 0);
    n = 0;
    while (!out_valid_a[2] && n < 100) begin
      @(negedge clk);
      n++;
    end
    bad = (n >= 100) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      if (digest_a[2] !== ABC_D || in_ready_a[2] !== 1'b0 || out_valid_a[2] !== 1'b1) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
    end
    out_ready_a[2] = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", 256'(in_ready_a[2]), 256'd1);
    chk("stall_release_out_valid", 256'(out_valid_a[2]), 256'd0);

    // Reset mid-round of block 2, then "abc" with first=0 must chain from H0.
    send(0, B1, 1, 0, '0, 0, '0, 0);
    wait_done(0);
    send(0, B2, 0, 1, '0, 0, '0, 0);
    repeat (30) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_in_ready", 256'(in_ready_a[0]), 256'd1);
    chk("abort_out_valid", 256'(out_valid_a[0]), 256'd0);
    chk("abort_digest", digest_a[0], 256'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    send(0, ABC, 0, 1, '0, 1, ABC_D, 0);
    wait_done(0);

    // External IV: block 1 from H0 via iv_in, block 2 restarted from the
    // block-1 chain via iv_in; in_valid held high while busy.
    send(3, B1, 1, 0, H_INIT, 0, '0, 0);
    wait_done(3);
    send(3, B2, 1, 1, H1, 1, TWO_D, 10);
    wait_done(3);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before limit");
    $fatal(1, "watchdog");
  end
endmodule
